// File: rtl/shift_deserializer_8bit.sv
// Serial-in, parallel-out receiver with a valid/ready holding register and a sticky overrun flag.
// Define SHIFT_DESER_PARITY_CHECK_EN to expect a trailing even-parity bit after each word.
module shift_deserializer_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             msb_first,
  input  logic             frame_start,
  input  logic             data_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1
`ifdef SHIFT_DESER_PARITY_CHECK_EN
    , S_PARITY = 2'd2
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               overrun_q, overrun_d;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
  logic               perr_q, perr_d;
  logic               perr_new;
`endif

  state_t             base_state;
  logic [WIDTH-1:0]   base_sr;
  logic [CNT_W-1:0]   base_cnt;
  logic [WIDTH-1:0]   word;
  logic               done;
  logic               drop;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic b,
                                                input logic dir);
    if (dir)
      return {sr[WIDTH-2:0], b};
    else
      return {b, sr[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
    perr_d       = perr_q;
    perr_new     = 1'b0;
`endif
    base_state   = state_q;
    base_sr      = sr_q;
    base_cnt     = cnt_q;
    word         = '0;
    done         = 1'b0;
    drop         = 1'b0;

    // frame_start clears collection first so a same-edge bit opens a fresh frame
    if (frame_start) begin
      base_state = S_IDLE;
      base_sr    = '0;
      base_cnt   = '0;
      state_d    = S_IDLE;
      sr_d       = '0;
      cnt_d      = '0;
    end

    if (bit_valid) begin
      case (base_state)
        S_IDLE: begin
          dir_d   = msb_first;
          sr_d    = shift_in('0, serial_in, msb_first);
          cnt_d   = CNT_W'(1);
          state_d = S_COLLECT;
        end
        S_COLLECT: begin
          word = shift_in(base_sr, serial_in, dir_q);
          if (base_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SHIFT_DESER_PARITY_CHECK_EN
            sr_d    = word;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_PARITY;
`else
            done    = 1'b1;
            sr_d    = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
`endif
          end else begin
            sr_d    = word;
            cnt_d   = base_cnt + CNT_W'(1);
            state_d = S_COLLECT;
          end
        end
`ifdef SHIFT_DESER_PARITY_CHECK_EN
        S_PARITY: begin
          word     = base_sr;
          perr_new = ^{base_sr, serial_in};
          done     = 1'b1;
          sr_d     = '0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end
`endif
        default: begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end

    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
      perr_d       = 1'b0;
`endif
    end

    // A completed word replaces the held one only if the holder is free or draining now
    if (done) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = word;
        data_valid_d = 1'b1;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
        perr_d       = perr_new;
`endif
      end else begin
        drop = 1'b1;
      end
    end

    if (overrun_clr)
      overrun_d = 1'b0;
    if (drop)
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
      perr_q       <= perr_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
